// File: rtl/hilo_muldiv.sv
// -----------------------------------------------------------------------------
// hilo_muldiv
//   Iterative 32x32 multiply / 32/32 divide unit writing the HI/LO pair.
//   One radix-2 step per cycle for 32 cycles (shift-add multiply, restoring
//   divide), followed by a single DONE cycle that presents the result together
//   with the HI/LO write enables. The issuing stage is stalled while the
//   operation is being accepted and while it runs.
//
// Ports
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   start    in   issue request (only looked at in IDLE)
//   op[1:0]  in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1     in   multiplicand / dividend
//   src2     in   multiplier / divisor
//   flush    in   abandon any operation in flight
//   stall_o  out  stall request to the issuing stage
//   hi_we    out  HI write enable (DONE only)
//   lo_we    out  LO write enable (DONE only)
//   hi_o     out  upper product / remainder (zero outside DONE)
//   lo_o     out  lower product / quotient  (zero outside DONE)
// -----------------------------------------------------------------------------
module hilo_muldiv (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stall_o,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;     // negate product / quotient at the end
    logic        r_neg_r;     // negate remainder at the end
    logic        r_dz;        // divide by zero
    logic [31:0] r_src1;      // raw dividend, returned in HI on divide by zero
    logic [31:0] r_a;         // multiplicand or divisor magnitude
    logic [31:0] r_hi;        // partial product high half / partial remainder
    logic [31:0] r_lo;        // multiplier shifting out / dividend->quotient
    logic        r_we;
    logic [31:0] r_hi_o;
    logic [31:0] r_lo_o;

    // Operand magnitudes at issue. Negating 0x80000000 yields 0x80000000,
    // which is exactly the unsigned magnitude we want.
    logic        w_signed;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    assign w_signed = ~op[0];
    assign w_mag1   = (w_signed && src1[31]) ? (32'd0 - src1) : src1;
    assign w_mag2   = (w_signed && src2[31]) ? (32'd0 - src2) : src2;

    // One iteration of either algorithm.
    logic [32:0] w_add;
    logic [32:0] w_shl;
    logic [33:0] w_diff;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_shl  = {r_hi, r_lo[31]};
    assign w_diff = {1'b0, w_shl} - {2'b00, r_a};

    always_comb begin
        w_hi = 32'd0;
        w_lo = 32'd0;
        if (r_is_div) begin
            // Restoring: keep the trial difference only when it did not borrow.
            // A non-borrowing difference is below the divisor, so it fits 32 bits.
            if (!w_diff[33]) begin
                w_hi = w_diff[31:0];
                w_lo = {r_lo[30:0], 1'b1};
            end else begin
                w_hi = w_shl[31:0];
                w_lo = {r_lo[30:0], 1'b0};
            end
        end else begin
            // Shift-add: the carry of the add moves into the top of HI.
            w_hi = w_add[32:1];
            w_lo = {w_add[0], r_lo[31:1]};
        end
    end

    logic w_unused_diff;
    assign w_unused_diff = w_diff[32];

    // Sign fix-up applied to the values produced by the final iteration.
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fin_hi;
    logic [31:0] w_fin_lo;
    assign w_prod = r_neg_q ? (64'd0 - {w_hi, w_lo}) : {w_hi, w_lo};
    assign w_quo  = r_neg_q ? (32'd0 - w_lo) : w_lo;
    assign w_rem  = r_neg_r ? (32'd0 - w_hi) : w_hi;

    always_comb begin
        w_fin_hi = w_prod[63:32];
        w_fin_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fin_hi = r_src1;
                w_fin_lo = 32'hFFFF_FFFF;
            end else begin
                w_fin_hi = w_rem;
                w_fin_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_src1   <= 32'd0;
            r_a      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_we     <= 1'b0;
            r_hi_o   <= 32'd0;
            r_lo_o   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we   <= 1'b0;
                    r_hi_o <= 32'd0;
                    r_lo_o <= 32'd0;
                    if (start && !flush) begin
                        r_state  <= S_RUN;
                        r_cnt    <= 5'd0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed && (src1[31] ^ src2[31]);
                        r_neg_r  <= w_signed && src1[31];
                        r_dz     <= (src2 == 32'd0);
                        r_src1   <= src1;
                        r_hi     <= 32'd0;
                        // Multiply: r_a is the multiplicand, r_lo the multiplier.
                        // Divide:   r_a is the divisor, r_lo the dividend.
                        r_a      <= op[1] ? w_mag2 : w_mag1;
                        r_lo     <= op[1] ? w_mag1 : w_mag2;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_hi;
                        r_lo  <= w_lo;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= S_DONE;
                            r_we    <= 1'b1;
                            r_hi_o  <= w_fin_hi;
                            r_lo_o  <= w_fin_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_hi_o  <= 32'd0;
                    r_lo_o  <= 32'd0;
                end
            endcase
        end
    end

    assign stall_o = ((r_state == S_IDLE) && start && !flush) || (r_state == S_RUN);
    // A flush arriving during DONE cancels the write in that same cycle.
    assign hi_we   = r_we && !flush;
    assign lo_we   = r_we && !flush;
    assign hi_o    = r_hi_o;
    assign lo_o    = r_lo_o;

endmodule

// File: tb/tb_hilo_muldiv.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv
//   Self-checking bench for hilo_muldiv: directed corner vectors, randomized
//   operations against a plain-arithmetic reference, flush and reset cases.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall_o;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests = 0;
    int fails = 0;

    hilo_muldiv dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .op      (op),
        .src1    (src1),
        .src2    (src2),
        .flush   (flush),
        .stall_o (stall_o),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    // Reference: results straight from 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = 32'd0;
        el = 32'd0;
        case (o)
            2'd0: begin r = sa * sb; eh = r[63:32]; el = r[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
            2'd2: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin r = sa / sb; el = r[31:0]; r = sa % sb; eh = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin eh = a % b; el = a / b; end
            end
        endcase
    endfunction

    // Issue one operation and follow it through all 34 cycles. With noisy set,
    // start is held high with junk operands while the operation runs.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, input string name);
        logic [31:0] eh;
        logic [31:0] el;
        int          bad_run;
        model(o, a, b, eh, el);
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1; flush = 1'b0;
        #1;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++;
            $display("FAIL %s issue_stall: stall_o=%b want 1", name, stall_o);
        end
        @(negedge clk);
        bad_run = 0;
        for (int k = 1; k <= 32; k++) begin
            if (noisy && k < 32) begin
                start = 1'b1; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if (stall_o !== 1'b1 || hi_we !== 1'b0 || lo_we !== 1'b0 ||
                hi_o !== 32'd0 || lo_o !== 32'd0)
                bad_run++;
            @(negedge clk);
        end
        #1;
        tests++;
        if (bad_run != 0) begin
            fails++;
            $display("FAIL %s run_phase: %0d bad RUN cycles want 0", name, bad_run);
        end
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b1 || lo_we !== 1'b1) begin
            fails++;
            $display("FAIL %s done_ctl: stall=%b hi_we=%b lo_we=%b want 0 1 1", name, stall_o, hi_we, lo_we);
        end
        tests++;
        if (hi_o !== eh) begin
            fails++;
            $display("FAIL %s hi_o: got %h want %h", name, hi_o, eh);
        end
        tests++;
        if (lo_o !== el) begin
            fails++;
            $display("FAIL %s lo_o: got %h want %h", name, lo_o, el);
        end
        $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)", name, o, a, b, hi_o, lo_o, eh, el);
        @(negedge clk);
        #1;
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            fails++;
            $display("FAIL %s after_done: stall=%b we=%b%b hi=%h lo=%h want all 0", name, stall_o, hi_we, lo_we, hi_o, lo_o);
        end
    endtask

    // Issue without following; returns at the negedge of the first RUN cycle.
    task automatic issue_only(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1; flush = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; src1 = 32'd0; src2 = 32'd0;
        #12;
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: stall=%b we=%b%b hi=%h lo=%h want all 0", stall_o, hi_we, lo_we, hi_o, lo_o);
        end
        $display("[TB] reset asserted, outputs stall=%b hi=%h lo=%h", stall_o, hi_o, lo_o);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_vectors();
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "mult_neg");
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(2'd3, 32'h0000_0064, 32'h0000_0000, 1'b0, "divu_zero");
        run_op(2'd2, 32'hFFFF_FF9C, 32'h0000_0000, 1'b0, "div_zero_neg");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, "mult_minmin_noisy");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(o, a, b, (i % 3) == 0, "random");
        end
    endtask

    task automatic test_flush_run();
        int we_seen;
        issue_only(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) begin
            fails++;
            $display("FAIL flush_run_next: stall=%b we=%b%b want 0 0 0", stall_o, hi_we, lo_we);
        end
        we_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hi_we !== 1'b0 || lo_we !== 1'b0) we_seen++;
        end
        tests++;
        if (we_seen != 0) begin
            fails++;
            $display("FAIL flush_run_nowrite: %0d write cycles want 0", we_seen);
        end
        $display("[TB] flush in RUN cycle 10, write pulses seen=%0d", we_seen);
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "reissue_after_flush");
    endtask

    task automatic test_flush_last();
        int we_seen;
        issue_only(2'd3, 32'hDEAD_BEEF, 32'h0000_0013);
        repeat (31) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        we_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (hi_we !== 1'b0 || lo_we !== 1'b0 || stall_o !== 1'b0 || hi_o !== 32'd0) we_seen++;
            @(negedge clk);
        end
        tests++;
        if (we_seen != 0) begin
            fails++;
            $display("FAIL flush_last_run: %0d cycles with write/stall/data want 0", we_seen);
        end
        $display("[TB] flush on final RUN edge, bad cycles=%0d", we_seen);
    endtask

    task automatic test_flush_done();
        issue_only(2'd0, 32'h0000_0003, 32'h0000_0005);
        repeat (32) @(negedge clk);
        flush = 1'b1;
        #1;
        tests++;
        if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
            fails++;
            $display("FAIL flush_done_we: we=%b%b want 00", hi_we, lo_we);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            fails++;
            $display("FAIL flush_done_after: stall=%b we=%b hi=%h lo=%h want 0", stall_o, hi_we, hi_o, lo_o);
        end
        $display("[TB] flush in DONE, we=%b%b", hi_we, lo_we);
    endtask

    task automatic test_flush_start();
        int bad;
        @(negedge clk);
        op = 2'd1; src1 = 32'd7; src2 = 32'd9; start = 1'b1; flush = 1'b1;
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_start_stall: stall_o=%b want 0", stall_o);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (stall_o !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL flush_start_idle: %0d active cycles want 0", bad);
        end
        $display("[TB] start with flush in IDLE, active cycles=%0d", bad);
    endtask

    task automatic test_reset_mid();
        int bad;
        issue_only(2'd2, 32'h7FFF_FFFF, 32'h0000_0003);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if (stall_o !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: stall=%b we=%b%b hi=%h lo=%h want all 0", stall_o, hi_we, lo_we, hi_o, lo_o);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        bad = (stall_o !== 1'b0 || hi_we !== 1'b0) ? 1 : 0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_release: stall=%b we=%b want 0 0", stall_o, hi_we);
        end
        $display("[TB] reset pulse during RUN, outputs cleared");
        run_op(2'd2, 32'h7FFF_FFFF, 32'h0000_0003, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_flush_run();
        test_flush_last();
        test_flush_done();
        test_flush_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
